// File: rtl/rf_pkg.sv
// rf_pkg: register-file geometry shared by the writeback path
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant with a pointer that advances past each accepted requester
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] j;
  logic any;
  always_comb begin
    gnt_idx = '0;
    any = 1'b0;
    j = '0;
    // scan from farthest to nearest so the requester closest to ptr wins
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        gnt_idx = j;
        any = 1'b1;
      end
    end
    gnt = (any && en && rst_n) ? N'(1) << gnt_idx : '0;
  end
  always_ff @(posedge clk)
    if (!rst_n) ptr <= '0;
    else if (|gnt) ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port among NREQ writeback sources
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hold,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic                   we3,
  output logic [ADDR_W-1:0]      wa3,
  output logic [DATA_W-1:0]      wd3,
  output logic                   wr_conflict,
  output logic [2:0]             grant_id
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [IW-1:0] idx;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic xfer, conf;
  rr_arbiter #(.N(NREQ)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req_valid), .en(!hold),
    .gnt(req_ready), .gnt_idx(idx)
  );
  always_comb begin
    addr = req_addr[idx*ADDR_W +: ADDR_W];
    data = req_data[idx*DATA_W +: DATA_W];
    xfer = |req_ready;
    conf = 1'b0;
    // conflicts are flagged regardless of hold: they describe what is requested, not granted
    for (int i = 0; i < NREQ; i++)
      for (int k = i + 1; k < NREQ; k++)
        if (req_valid[i] && req_valid[k] &&
            req_addr[i*ADDR_W +: ADDR_W] == req_addr[k*ADDR_W +: ADDR_W] &&
            req_addr[i*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))
          conf = 1'b1;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
      wr_conflict <= 1'b0;
      grant_id <= '0;
    end else begin
      we3 <= xfer && addr != ADDR_W'(REG_ZERO);
      wr_conflict <= conf;
      if (xfer) begin
        wa3 <= addr;
        wd3 <= data;
        grant_id <= 3'(idx);
      end
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Round-robin arbiter that shares the single register-file write port (we3/wa3/wd3) among NREQ writeback sources, e.g. ALU writeback, load unit and multicycle mul/div. Each source uses a valid/ready handshake. At most one write is granted per cycle. The granted write is registered on the rising edge, so the register file commits it on the falling edge of the following cycle. Sits between the pipeline writeback stage and reg_file.

Parameters:
NREQ, 3, number of write requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, write data width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
hold  input  1  when 1, no new grants are issued (debug/stall freeze)
req_valid  input  NREQ  per-requester write request
req_ready  output  NREQ  per-requester grant; one-hot or zero, combinational
req_addr  input  NREQ*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W]
req_data  input  NREQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
we3  output  1  register-file write enable (registered)
wa3  output  ADDR_W  register-file write address (registered)
wd3  output  DATA_W  register-file write data (registered)
wr_conflict  output  1  registered pulse: in the previous cycle, two or more valid requests targeted the same nonzero address
grant_id  output  3  index of the last accepted requester (registered)

Behaviour:
- Reset (rst_n=0 at a rising edge): we3=0, wa3=0, wd3=0, wr_conflict=0, grant_id=0, round-robin pointer ptr=0. req_ready is forced to 0 while rst_n=0.
- Arbitration is combinational each cycle. The winner is the first i with req_valid[i]=1, searching from ptr upward and wrapping modulo NREQ. req_ready[winner]=1 and all other bits are 0. If hold=1, or no request is valid, req_ready is all zeros.
- Transfer happens when req_valid[i] && req_ready[i] is true at a rising edge.
- On a transfer from requester i:
  - next cycle: wa3=req_addr[i], wd3=req_data[i], grant_id=i, we3=(req_addr[i]!=0);
  - ptr becomes (i+1) mod NREQ.
- When no transfer occurs: we3=0 next cycle, wa3/wd3 hold their previous values, ptr is unchanged.
- Writes to r0 are accepted (ready asserted, pointer advances) but never produce we3=1.
- Latency: a request accepted at edge k is visible on we3/wa3/wd3 during cycle k+1 and is written into the register file at the falling edge of cycle k+1. Its bypass is visible on rd1/rd2 throughout cycle k+1.
- Requester rule: once req_valid[i] is raised, it and req_addr/req_data must stay stable until accepted. The arbiter never drops a pending request.
- Fairness: a continuously valid requester is granted within NREQ cycles of hold deasserting.
- wr_conflict: set for one cycle after any edge where at least two valid requests share a nonzero address. Ordering between them follows round-robin; the later grant wins the register.
- hold=1 does not cancel an already-registered write. we3 from the previous edge still appears.
- Reset asserted mid-operation: the pending registered write is discarded (we3=0 from the next cycle) and ptr returns to 0.

Decomposition:
- Shared package rf_pkg: REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, REG_ZERO=0.
- One sub-module, rr_arbiter: parameter N; inputs clk, rst_n, req[N], en; outputs gnt[N] (one-hot) and gnt_idx. It owns the pointer and its update on accept.
- rf_wb_arbiter adds the payload mux, output registers, r0 suppression and conflict detection.

Test Plan:
1. Reset held 2 cycles with req_valid=3'b111 -> req_ready=0, we3=0; after release, first grant goes to req 0.
2. req_valid=3'b111 held with addrs 1,2,3 and data A,B,C -> grants 0,1,2 on consecutive edges; we3=1 with (wa3,wd3)=(1,A),(2,B),(3,C) in the following cycles; reg_file rd of r3 reads C afterwards.
3. Only req 2 valid, addr 0, data 0xDEADBEEF -> req_ready[2]=1, we3 stays 0, grant_id=2, r0 still reads 0.
4. req 0 and req 1 both valid with addr 7 (data 0x11, 0x22) and ptr=0 -> wr_conflict=1 for one cycle; r7 ends at 0x22.
5. hold=1 for 4 cycles with req 1 valid -> no ready, we3=0; on hold release, req 1 is granted within 1 cycle with unchanged payload.
6. rst_n dropped in the cycle after an accept -> we3=0 next cycle; the register is not written; ptr=0.
